mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Moore FSM sequencing the shared multicycle datapath (one ALU, one memory port): fetch, decode,
//  execute, memory, writeback. Drives ALU-control ALUOp (00 add, 01 sub, 10 funct), mux selects,
//  write strobes. Stalls on memory handshake; counts retired instructions.
// PARAMETERS
//  CNT_W   16   width of retired-instruction counter
// PORTS
//  clk            in   1      sole clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  opcode         in   6      IR[31:26]; valid from DECODE onward
//  mem_ready      in   1      memory completes access this cycle
//  alu_op         out  2      to ALU control
//  alu_src_a      out  1      0 PC, 1 reg A
//  alu_src_b      out  2      00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  pc_source      out  2      00 ALU result, 01 ALUOut, 10 jump target
//  pc_write / pc_write_cond / ir_write / reg_write / mem_write / mem_read   out 1 each
//  iord / reg_dst / mem_to_reg   out 1 each
//  illegal_op     out  1      one-cycle pulse on unknown opcode
//  retired        out  CNT_W  retired-instruction count
//  state          out  4      current state (debug)
// BEHAVIOUR
//  States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6,
//   RTYPE_WB 7, BEQ_EX 8, ADDI_EX 9, ADDI_WB 10, JUMP 11; 12-15 unused -> FETCH next cycle.
//  Reset: state=FETCH, retired=0; while reset_n low every other output forced 0.
//  Outputs are pure decode of state (plus mem_ready where noted); unlisted outputs 0:
//   FETCH: mem_read, src_a=0, src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
//   DECODE: src_a=0, src_b=11, alu_op=00.  MEMADR/ADDI_EX: src_a=1, src_b=10, alu_op=00.
//   MEMRD: mem_read, iord.  MEMWR: mem_write, iord.  MEMWB: reg_write, mem_to_reg, reg_dst=0.
//   RTYPE_EX: src_a=1, src_b=00, alu_op=10.  RTYPE_WB: reg_write, reg_dst=1, mem_to_reg=0.
//   BEQ_EX: src_a=1, src_b=00, alu_op=01, pc_write_cond, pc_source=01.
//   ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0.  JUMP: pc_write, pc_source=10.
//  Transitions: FETCH holds until mem_ready, then DECODE. DECODE by opcode: 100011/101011 ->
//   MEMADR; 000000 -> RTYPE_EX; 000100 -> BEQ_EX; 001000 -> ADDI_EX; 000010 -> JUMP (if enabled);
//   else -> FETCH with illegal_op=1 during the DECODE cycle, not retired.
//   MEMADR -> MEMRD (lw) / MEMWR (sw), opcode re-read. MEMRD holds until mem_ready -> MEMWB.
//   MEMWR holds until mem_ready -> FETCH. RTYPE_EX->RTYPE_WB, ADDI_EX->ADDI_WB, then FETCH.
//   MEMWB, BEQ_EX, JUMP -> FETCH.
//  Latency (mem_ready=1): lw 5, sw 4, R/addi 4, beq 3, j 3 cycles.
//  retired increments on the edge leaving a terminal state (MEMWB, MEMWR w/ mem_ready, RTYPE_WB,
//   ADDI_WB, BEQ_EX, JUMP) into FETCH; wraps 2^CNT_W-1 -> 0 silently.
//  mem_ready ignored in non-memory states. Opcode change mid-instruction after DECODE only affects
//   MEMADR's lw/sw choice. Reset mid-instruction aborts at once; no strobe asserted after assertion.
// CONFIGURATION
//  MIPS_JUMP_EN defined: opcode 000010 -> JUMP state (pc_write, pc_source=10), retired.
//  Undefined: JUMP state not built, 000010 treated as illegal (illegal_op pulse, -> FETCH),
//   pc_source never 10; state code 11 unused.
// TESTING
//  Reset low mid-RTYPE_EX -> all strobes 0, state=0, retired=0 immediately; release -> FETCH.
//  lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write+mem_to_reg only in 4; retired=1.
//  sw with mem_ready low 3 cycles in MEMWR -> state 5 held 4 cycles, mem_write+iord held, one retire.
//  R-type then beq -> alu_op 10 in state 6, 01 with pc_write_cond in state 8; retired=2.
//  Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, next state 0, retired unchanged.
//  Preload retired=all-ones via 2^CNT_W retirements (CNT_W=4) -> wraps to 0; j with/without MIPS_JUMP_EN.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore sequencer for a shared-ALU, single-memory-port
// multicycle MIPS datapath. Decodes state into ALU/mux selects and write strobes,
// stalls on the memory handshake and counts retired instructions.
// Build option: define MIPS_JUMP_EN to add the JUMP state (opcode 000010);
// otherwise 000010 decodes as illegal and state code 11 is unused.
module mips_multicycle_control #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             reg_write,
   output logic             mem_write,
   output logic             mem_read,
   output logic             iord,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMRD    = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWR    = 4'd5,
      ST_RTYPE_EX = 4'd6,
      ST_RTYPE_WB = 4'd7,
      ST_BEQ_EX   = 4'd8,
      ST_ADDI_EX  = 4'd9,
`ifdef MIPS_JUMP_EN
      ST_ADDI_WB  = 4'd10,
      ST_JUMP     = 4'd11
`else
      ST_ADDI_WB  = 4'd10
`endif
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_illegal;
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;

   // State register; reset parks the sequencer in FETCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_FETCH;
      else          r_state <= w_next;
   end

   // Next-state, illegal-opcode flag and retire strobe
   always_comb begin
      w_next    = ST_FETCH;
      w_illegal = 1'b0;
      w_retire  = 1'b0;
      case (r_state)
         ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = ST_MEMADR;
               OP_RTYPE:     w_next = ST_RTYPE_EX;
               OP_BEQ:       w_next = ST_BEQ_EX;
               OP_ADDI:      w_next = ST_ADDI_EX;
`ifdef MIPS_JUMP_EN
               OP_J:         w_next = ST_JUMP;
`endif
               default: begin
                  w_next    = ST_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         // lw/sw is re-decoded here; anything other than sw takes the load path
         ST_MEMADR:   w_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:    w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWB: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_MEMWR: begin
            w_next   = mem_ready ? ST_FETCH : ST_MEMWR;
            w_retire = mem_ready;
         end
         ST_RTYPE_EX: w_next = ST_RTYPE_WB;
         ST_RTYPE_WB: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_BEQ_EX: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_ADDI_EX:  w_next = ST_ADDI_WB;
         ST_ADDI_WB: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
`ifdef MIPS_JUMP_EN
         ST_JUMP: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
`endif
         default:     w_next = ST_FETCH;
      endcase
   end

   // Retired-instruction counter; wraps silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + CNT_W'(1);
   end

   // Control decode of the current state; everything held low while in reset
   always_comb begin
      alu_op        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      mem_read      = 1'b0;
      iord          = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_op    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = w_illegal;
         end
         ST_MEMADR, ST_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ST_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         ST_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         ST_RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BEQ_EX: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         ST_ADDI_WB:  reg_write = 1'b1;
`ifdef MIPS_JUMP_EN
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
`endif
         default: ;
      endcase
      if (!reset_n) begin
         alu_op        = 2'b00;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         pc_source     = 2'b00;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_write     = 1'b0;
         mem_read      = 1'b0;
         iord          = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         illegal_op    = 1'b0;
      end
   end

   assign retired = r_retired;
   assign state   = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed vectors for the multicycle control FSM,
// counter width 4 so the retire counter wrap is reachable.
// Expectations follow MIPS_JUMP_EN when it is defined for the build.
module tb_mips_multicycle_control;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic [1:0]       alu_op;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       pc_source;
   logic             pc_write;
   logic             pc_write_cond;
   logic             ir_write;
   logic             reg_write;
   logic             mem_write;
   logic             mem_read;
   logic             iord;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             illegal_op;
   logic [CNT_W-1:0] retired;
   logic [3:0]       state;
   logic [15:0]      ctl_w;

   int n_vec = 0;
   int n_err = 0;
   int exp_ret = 0;

   mips_multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
      .mem_read(mem_read), .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal_op(illegal_op), .retired(retired), .state(state)
   );

   // Control outputs packed for compact comparison
   assign ctl_w = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                   ir_write, reg_write, mem_write, mem_read, iord, reg_dst, mem_to_reg};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hand-computed control words per state (mem_ready only matters in FETCH)
   function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
      case (st)
         4'd0:    exp_ctl = mr ? 16'h0948 : 16'h0808;
         4'd1:    exp_ctl = 16'h1800;
         4'd2:    exp_ctl = 16'h3000;
         4'd3:    exp_ctl = 16'h000C;
         4'd4:    exp_ctl = 16'h0021;
         4'd5:    exp_ctl = 16'h0014;
         4'd6:    exp_ctl = 16'hA000;
         4'd7:    exp_ctl = 16'h0022;
         4'd8:    exp_ctl = 16'h6280;
         4'd9:    exp_ctl = 16'h3000;
         4'd10:   exp_ctl = 16'h0020;
         4'd11:   exp_ctl = 16'h0500;
         default: exp_ctl = 16'h0000;
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One instruction with mem_ready high; seq lists states, nibble 0 first
   task automatic run_instr(input string tag, input logic [5:0] op, input int n,
                            input logic [23:0] seq, input logic ill);
      logic [3:0] st;
      opcode    = op;
      mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         st = seq[4*i +: 4];
         #1;
         chk({tag, "_st"},  32'(state), 32'(st));
         chk({tag, "_ctl"}, 32'(ctl_w), 32'(exp_ctl(st, 1'b1)));
         chk({tag, "_ill"}, 32'(illegal_op), 32'((st == 4'd1) && ill));
         cyc();
      end
      #1;
      if (!ill) exp_ret++;
      chk({tag, "_end_st"}, 32'(state), 32'd0);
      chk({tag, "_ret"}, 32'(retired), 32'(exp_ret % 16));
   endtask

   initial begin
      reset_n   = 1'b0;
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      #3;
      chk("rst_st",  32'(state), 32'd0);
      chk("rst_ctl", 32'(ctl_w), 32'd0);
      chk("rst_ret", 32'(retired), 32'd0);
      cyc();
      reset_n   = 1'b1;
      mem_ready = 1'b0;
      #1;
      chk("fetch_wait_ctl", 32'(ctl_w), 32'h0808);
      cyc();
      chk("fetch_hold_st", 32'(state), 32'd0);

      run_instr("lw", 6'b100011, 5, 24'h043210, 1'b0);

      // sw with a three-cycle memory stall in MEMWR
      opcode    = 6'b101011;
      mem_ready = 1'b1;
      #1;
      chk("sw_f_st", 32'(state), 32'd0);
      cyc();
      chk("sw_d_st", 32'(state), 32'd1);
      cyc();
      chk("sw_a_st", 32'(state), 32'd2);
      mem_ready = 1'b0;
      cyc();
      for (int k = 0; k < 3; k++) begin
         chk("sw_stall_st",  32'(state), 32'd5);
         chk("sw_stall_ctl", 32'(ctl_w), 32'h0014);
         cyc();
      end
      mem_ready = 1'b1;
      #1;
      chk("sw_last_st",  32'(state), 32'd5);
      chk("sw_last_ctl", 32'(ctl_w), 32'h0014);
      chk("sw_last_ret", 32'(retired), 32'(exp_ret));
      cyc();
      exp_ret++;
      chk("sw_end_st",  32'(state), 32'd0);
      chk("sw_end_ret", 32'(retired), 32'(exp_ret));

      run_instr("rtype", 6'b000000, 4, 24'h007610, 1'b0);
      run_instr("beq",   6'b000100, 3, 24'h000810, 1'b0);
      run_instr("addi",  6'b001000, 4, 24'h00A910, 1'b0);
      run_instr("illeg", 6'b111111, 2, 24'h000010, 1'b1);
`ifdef MIPS_JUMP_EN
      run_instr("jump",  6'b000010, 3, 24'h000B10, 1'b0);
`else
      run_instr("jump",  6'b000010, 2, 24'h000010, 1'b1);
`endif

      // Reset asserted in the middle of RTYPE_EX
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      cyc();
      cyc();
      chk("mid_ex_st",  32'(state), 32'd6);
      chk("mid_ex_ctl", 32'(ctl_w), 32'hA000);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_st",  32'(state), 32'd0);
      chk("mid_rst_ctl", 32'(ctl_w), 32'd0);
      chk("mid_rst_ret", 32'(retired), 32'd0);
      exp_ret = 0;
      cyc();
      reset_n = 1'b1;
      #1;
      chk("post_rst_st",  32'(state), 32'd0);
      chk("post_rst_ctl", 32'(ctl_w), 32'h0948);

      // Sixteen retirements wrap the 4-bit counter back to zero
      for (int k = 0; k < 16; k++) run_instr("wrap_beq", 6'b000100, 3, 24'h000810, 1'b0);
      chk("wrap_zero", 32'(retired), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
